// File: rtl/riscv_load_wb_stage.sv
// Load writeback stage: waits for one or two data-memory responses per load,
// aligns and extends the loaded bytes, and writes them to the register file with their DIFT tag.
module riscv_load_wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    output logic                  wb_ready_o,
    input  logic                  regfile_we_i,
    input  logic [ADDR_WIDTH-1:0] regfile_waddr_i,
    input  logic [1:0]            data_type_i,
    input  logic                  data_sign_ext_i,
    input  logic [1:0]            addr_lsb_i,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    input  logic                  data_rtag_i,
    output logic                  regfile_we_o,
    output logic [ADDR_WIDTH-1:0] regfile_waddr_o,
    output logic [DATA_WIDTH-1:0] regfile_wdata_o,
    output logic                  regfile_wdata_tag_o,
    output logic                  busy_o
);

    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        WAIT_SECOND
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   waddr_q;
    logic [1:0]              type_q;
    logic                    sign_q;
    logic [1:0]              lsb_q;
    logic                    mis_q;
    logic [DATA_WIDTH-1:0]   first_word_q;
    logic                    first_tag_q;

    logic                    we_out_q;
    logic [ADDR_WIDTH-1:0]   waddr_out_q;
    logic [DATA_WIDTH-1:0]   wdata_out_q;
    logic                    tag_out_q;

    logic                    final_rsp;
    logic                    accept;
    logic                    mis_d;
    logic [7:0]              src_bytes [2*NB];
    logic [DATA_WIDTH-1:0]   aligned_word;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic                    tag_d;

    assign final_rsp  = data_rvalid_i &
                        (((state_q == WAIT_FIRST) & ~mis_q) | (state_q == WAIT_SECOND));
    assign wb_ready_o = (state_q == IDLE) | final_rsp;
    assign accept     = ex_valid_i & wb_ready_o & regfile_we_i;
    assign mis_d      = (data_type_i[1] & (addr_lsb_i != 2'd0)) |
                        ((data_type_i == 2'b01) & (addr_lsb_i == 2'd3));

    // Byte stream seen by the load: the current response alone, or the stored first
    // response followed by the second one when the access straddles a word boundary.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_src
            assign src_bytes[gi]      = (state_q == WAIT_SECOND) ? first_word_q[8*gi +: 8]
                                                                 : data_rdata_i[8*gi +: 8];
            assign src_bytes[gi + NB] = (state_q == WAIT_SECOND) ? data_rdata_i[8*gi +: 8]
                                                                 : 8'h00;
        end
        for (genvar gi = 0; gi < NB; gi++) begin : g_align
            localparam logic [2:0] OFF = 3'(gi);
            assign aligned_word[8*gi +: 8] = src_bytes[OFF + {1'b0, lsb_q}];
        end
    endgenerate

    always_comb begin
        wdata_d = aligned_word;
        case (type_q)
            2'b00:   wdata_d = {{24{sign_q & aligned_word[7]}},  aligned_word[7:0]};
            2'b01:   wdata_d = {{16{sign_q & aligned_word[15]}}, aligned_word[15:0]};
            default: wdata_d = aligned_word;
        endcase
    end

    assign tag_d = data_rtag_i | ((state_q == WAIT_SECOND) & first_tag_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            type_q       <= '0;
            sign_q       <= 1'b0;
            lsb_q        <= '0;
            mis_q        <= 1'b0;
            first_word_q <= '0;
            first_tag_q  <= 1'b0;
            we_out_q     <= 1'b0;
            waddr_out_q  <= '0;
            wdata_out_q  <= '0;
            tag_out_q    <= 1'b0;
        end else begin
            we_out_q <= 1'b0;
            if (final_rsp) begin
                we_out_q    <= 1'b1;
                waddr_out_q <= waddr_q;
                wdata_out_q <= wdata_d;
                tag_out_q   <= tag_d;
            end

            case (state_q)
                IDLE: begin
                    if (accept) state_q <= WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (data_rvalid_i) begin
                        if (mis_q) begin
                            first_word_q <= data_rdata_i;
                            first_tag_q  <= data_rtag_i;
                            state_q      <= WAIT_SECOND;
                        end else begin
                            state_q <= accept ? WAIT_FIRST : IDLE;
                        end
                    end
                end
                WAIT_SECOND: begin
                    if (data_rvalid_i) state_q <= accept ? WAIT_FIRST : IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (accept) begin
                waddr_q <= regfile_waddr_i;
                type_q  <= data_type_i;
                sign_q  <= data_sign_ext_i;
                lsb_q   <= addr_lsb_i;
                mis_q   <= mis_d;
            end
        end
    end

    assign regfile_we_o        = we_out_q;
    assign regfile_waddr_o     = waddr_out_q;
    assign regfile_wdata_o     = wdata_out_q;
    assign regfile_wdata_tag_o = tag_out_q;
    assign busy_o              = (state_q != IDLE);

endmodule

// File: doc/riscv_load_wb_stage.md
Name: riscv_load_wb_stage

Overview:
- Writeback stage for load results, directly downstream of the execute stage's EX/WB pipeline register.
- Captures each load instruction handed over by execute and waits for the data-memory response(s).
- Aligns and sign/zero-extends the returned data, merging two responses for misaligned accesses.
- Drives the register-file load write port and propagates the DIFT tag of the loaded data.
- Back-pressures execute through wb_ready_o.

Parameters:
- DATA_WIDTH, 32, data path width; only 32 is supported.
- ADDR_WIDTH, 5, register-file write address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ex_valid_i  in  1  execute hands over an instruction this cycle
- wb_ready_o  out  1  stage can accept an instruction this cycle
- regfile_we_i  in  1  handed-over instruction is a load needing writeback
- regfile_waddr_i  in  5  destination register
- data_type_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- data_sign_ext_i  in  1  1 sign-extend, 0 zero-extend
- addr_lsb_i  in  2  byte offset of the load address
- data_rvalid_i  in  1  memory response valid
- data_rdata_i  in  32  memory response data (little-endian)
- data_rtag_i  in  1  DIFT tag of the response word
- regfile_we_o  out  1  register-file write enable (one-cycle pulse)
- regfile_waddr_o  out  5  write address
- regfile_wdata_o  out  32  aligned, extended load data
- regfile_wdata_tag_o  out  1  DIFT tag of written data
- busy_o  out  1  load outstanding (state != IDLE)

Behaviour:
- Reset: synchronous; clk edge with rst_n=0 → state IDLE, all captured fields 0, regfile_we_o=0, regfile_waddr_o=0, regfile_wdata_o=0, regfile_wdata_tag_o=0, busy_o=0. Reset mid-operation abandons the outstanding load and produces no write. Responses arriving after reset are ignored in IDLE.
- Accept: fires when ex_valid_i & wb_ready_o & regfile_we_i. Captures waddr, type, sign_ext, addr_lsb. Computes misaligned = (word & lsb!=0) | (half & lsb==3).
- Handover with regfile_we_i=0: consumed, no state change, no write.
- FSM states and transitions:
  - IDLE: accept → WAIT_FIRST.
  - WAIT_FIRST: rvalid & !misaligned → finish. rvalid & misaligned → store first word and its tag, go to WAIT_SECOND.
  - WAIT_SECOND: rvalid → finish.
  - finish: go to IDLE, or directly to WAIT_FIRST if a new accept occurs in the same cycle.
- wb_ready_o: 1 when state==IDLE, or when the final response arrives this cycle (combinational from data_rvalid_i). Otherwise 0. This allows back-to-back loads with no bubble.
- Write latency: regfile_we_o pulses high exactly one cycle after the final rvalid, registered, with matching waddr, wdata and tag. Output registers hold their values while regfile_we_o=0.
- Alignment, aligned cases (b_k = byte k of the response):
  - Byte: b_lsb.
  - Half lsb 0/1/2: {b_(lsb+1), b_lsb}.
  - Word lsb 0: whole response.
- Alignment, misaligned cases (F = first response, S = second response):
  - Half lsb 3: {S.b0, F.b3}.
  - Word lsb k: bytes k..3 of F form the low bytes, bytes 0..k-1 of S form the high bytes.
- Extension: sign-extend from bit 7 (byte) or bit 15 (half) when data_sign_ext_i=1, else zero-extend. Words are unchanged.
- Tag: OR of the tags of all responses used for the load.
- Unexpected inputs:
  - rvalid while IDLE is ignored.
  - ex_valid_i while wb_ready_o=0 is not accepted; execute must hold its outputs.

Test Plan:
- Aligned word: accept lsb=0, waddr=5; next cycle rvalid 0xDEADBEEF, tag 0 → one cycle later we=1, waddr=5, wdata=0xDEADBEEF, tag=0; wb_ready_o=1 during the rvalid cycle.
- Signed byte: type=00, lsb=3, sign=1, rdata=0x80112233 → wdata=0xFFFFFF80; same with sign=0 → 0x00000080.
- Misaligned word: lsb=1, first response 0xAABBCCDD tag 0, second 0x11223344 tag 1 → wdata=0x44AABBCC, tag=1; wb_ready_o=0 between the two responses; single write pulse.
- Misaligned half: lsb=3, unsigned, responses 0xAA000000 then 0x00000044 → wdata=0x000044AA; with sign=1 and second response 0x00000084 → 0xFFFF84AA.
- Back-to-back: new load accepted in the same cycle as the prior load's final rvalid → two consecutive write pulses, correct addresses, no lost response.
- Reset mid-op: rst_n low while in WAIT_SECOND, then rvalid after reset → busy_o=0, no regfile_we_o pulse, outputs 0.
